// File: rtl/tiletest_switch_conditioner.sv
// tiletest_switch_conditioner
//
// Front-panel switch conditioning for the tiletester. Each raw pin passes
// through a two-flop synchroniser and a per-switch debounce FSM. The block
// produces a clean level, one-cycle rise/fall strobes, sticky press flags
// and, optionally, saturating per-switch press counters.
//
// Optional feature: define TILETEST_SW_PRESS_COUNT_EN to build the press
// counters. Without it, press_count is tied to zero, count_clr is unused,
// and the port list stays the same.

module tiletest_switch_conditioner #(
  parameter int N_SW            = 5,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic [N_SW-1:0]       sw_raw,
  input  logic [N_SW-1:0]       flag_clr,
  input  logic                  count_clr,
  output logic [N_SW-1:0]       sw_state,
  output logic [N_SW-1:0]       sw_rise,
  output logic [N_SW-1:0]       sw_fall,
  output logic [N_SW-1:0]       press_flag,
  output logic [N_SW*CNT_W-1:0] press_count
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; it never wraps.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } sw_st_e;

  logic [N_SW-1:0] sync1_q;
  logic [N_SW-1:0] sync2_q;

  sw_st_e          st_q  [N_SW];
  sw_st_e          st_d  [N_SW];
  logic [DB_W-1:0] cnt_q [N_SW];
  logic [DB_W-1:0] cnt_d [N_SW];

  logic [N_SW-1:0] state_q, state_d;
  logic [N_SW-1:0] rise_q,  rise_d;
  logic [N_SW-1:0] fall_q,  fall_d;
  logic [N_SW-1:0] flag_q,  flag_d;

  // Two-flop synchroniser; only sync2 feeds the debounce logic.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: a new level must be held DEBOUNCE_CYCLES cycles
  // before it is accepted; any reversion while pending is rejected silently.
  always_comb begin
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_SW; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        STABLE_LO: begin
          if (sync2_q[i]) begin
            st_d[i]  = PEND_HI;
            cnt_d[i] = DB_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        PEND_HI: begin
          if (!sync2_q[i]) begin
            st_d[i]  = STABLE_LO;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i]    = STABLE_HI;
            cnt_d[i]   = '0;
            state_d[i] = 1'b1;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DB_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync2_q[i]) begin
            st_d[i]  = PEND_LO;
            cnt_d[i] = DB_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        PEND_LO: begin
          if (sync2_q[i]) begin
            st_d[i]  = STABLE_HI;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i]    = STABLE_LO;
            cnt_d[i]   = '0;
            state_d[i] = 1'b0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DB_ONE;
          end
        end
        default: begin
          st_d[i]  = STABLE_LO;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Debounce state, counters and the registered level/strobe outputs.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_SW; i++) begin
        st_q[i]  <= STABLE_LO;
        cnt_q[i] <= '0;
      end
      state_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Sticky press flag: a rise on the same edge as a clear keeps the flag set.
  always_comb begin
    flag_d = rise_q | (flag_q & ~flag_clr);
  end

  // Press flag register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_d;
    end
  end

`ifdef TILETEST_SW_PRESS_COUNT_EN
  // Packed so that switch i lands at [i*CNT_W +: CNT_W] when flattened.
  logic [N_SW-1:0][CNT_W-1:0] pcnt_q, pcnt_d;

  // Saturating press counters; a global clear beats a same-edge increment.
  always_comb begin
    pcnt_d = pcnt_q;
    for (int i = 0; i < N_SW; i++) begin
      if (count_clr) begin
        pcnt_d[i] = '0;
      end else if (rise_q[i] && (pcnt_q[i] != {CNT_W{1'b1}})) begin
        pcnt_d[i] = pcnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Press counter register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign press_count = pcnt_q;
`else
  // Counters not built: the clear input has no effect.
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign press_count      = '0;
`endif

  assign sw_state   = state_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign press_flag = flag_q;

endmodule

// File: tb/tb_tiletest_switch_conditioner.sv
// Bench for tiletest_switch_conditioner (DEBOUNCE_CYCLES=4, N_SW=5, CNT_W=8).
// Each accepted transition pushes its expected strobe (kind, switch, cycle)
// into a queue when driven; a negedge monitor pops and compares as strobes
// appear. Counter checks are built when TILETEST_SW_PRESS_COUNT_EN is set.

module tb_tiletest_switch_conditioner;

  localparam int N   = 5;
  localparam int DEB = 4;
  localparam int CW  = 8;

  logic            sys_clk;
  logic            reset_n;
  logic [N-1:0]    sw_raw;
  logic [N-1:0]    flag_clr;
  logic            count_clr;
  logic [N-1:0]    sw_state;
  logic [N-1:0]    sw_rise;
  logic [N-1:0]    sw_fall;
  logic [N-1:0]    press_flag;
  logic [N*CW-1:0] press_count;

  tiletest_switch_conditioner #(
    .N_SW(N), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .flag_clr(flag_clr), .count_clr(count_clr), .sw_state(sw_state),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .press_flag(press_flag),
    .press_count(press_count)
  );

  typedef logic [63:0] ev_t;

  ev_t          sb_q[$];
  int           n_checks = 0;
  int           n_errs   = 0;
  int           cyc      = 0;
  logic [N-1:0] rise_prev;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input bit rise, input int sw, input int c);
    return {23'b0, rise, 8'(sw), 32'(c)};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called at a negedge: edge 1 is the next posedge, strobe seen DEB+2 edges on.
  task automatic drive_sw(input int i, input logic v, input bit expect_ev);
    sw_raw[i] = v;
    if (expect_ev) sb_q.push_back(mk_ev(v, i, cyc + DEB + 2));
  endtask

  // Strobe monitor: every strobe must match the next expected event exactly.
  always @(negedge sys_clk) begin
    ev_t e;
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (rise_prev[i]) check_eq("flag_after_rise", press_flag[i], 1'b1);
        if (sw_rise[i]) begin
          e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
          check_eq("rise_event", mk_ev(1'b1, i, cyc), e);
          check_eq("rise_state", sw_state[i], 1'b1);
        end
        if (sw_fall[i]) begin
          e = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
          check_eq("fall_event", mk_ev(1'b0, i, cyc), e);
          check_eq("fall_state", sw_state[i], 1'b0);
        end
      end
      rise_prev = sw_rise;
    end else begin
      rise_prev = '0;
    end
  end

  initial begin
    reset_n   = 1'b0;
    sw_raw    = '0;
    flag_clr  = '0;
    count_clr = 1'b0;
    rise_prev = '0;
    wait_n(3);

    check_eq("rst_state", sw_state, 0);
    check_eq("rst_rise",  sw_rise, 0);
    check_eq("rst_fall",  sw_fall, 0);
    check_eq("rst_flag",  press_flag, 0);
    check_eq("rst_count", press_count, 0);
    reset_n = 1'b1;
    wait_n(2);

    // Clean edge on switch 0.
    drive_sw(0, 1'b1, 1'b1);
    wait_n(8);
    check_eq("clean_state", sw_state[0], 1'b1);
    check_eq("clean_flag",  press_flag[0], 1'b1);

    // Bounce on switch 1: 3-cycle high rejected, then a held high accepted.
    drive_sw(1, 1'b1, 1'b0);
    wait_n(3);
    drive_sw(1, 1'b0, 1'b0);
    wait_n(10);
    check_eq("bounce_state", sw_state[1], 1'b0);
    check_eq("bounce_flag",  press_flag[1], 1'b0);
    drive_sw(1, 1'b1, 1'b1);
    wait_n(10);
    check_eq("bounce_accept", sw_state[1], 1'b1);

    // Release on switch 2: flag keeps its value through the fall.
    drive_sw(2, 1'b1, 1'b1);
    wait_n(10);
    drive_sw(2, 1'b0, 1'b1);
    wait_n(10);
    check_eq("release_state", sw_state[2], 1'b0);
    check_eq("release_flag",  press_flag[2], 1'b1);

    // Flag clear race on switch 3: same-edge set wins, next-edge clear wins.
    drive_sw(3, 1'b1, 1'b1);
    wait_n(6);
    flag_clr[3] = 1'b1;
    wait_n(1);
    check_eq("race_set_wins", press_flag[3], 1'b1);
    wait_n(1);
    check_eq("race_clear", press_flag[3], 1'b0);
    flag_clr[3] = 1'b0;
    wait_n(2);
    check_eq("clear_isolated", press_flag, 5'b00111);

    // Bring every switch back low before the reset test.
    drive_sw(0, 1'b0, 1'b1);
    drive_sw(1, 1'b0, 1'b1);
    drive_sw(3, 1'b0, 1'b1);
    wait_n(10);
    check_eq("all_low", sw_state, 0);

    // Reset while switch 4 is pending with counter=2.
    drive_sw(4, 1'b1, 1'b0);
    wait_n(4);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_state", sw_state, 0);
    check_eq("midrst_flag",  press_flag, 0);
    check_eq("midrst_strb",  {sw_rise, sw_fall}, 0);
    wait_n(2);
    reset_n = 1'b1;
    sb_q.push_back(mk_ev(1'b1, 4, cyc + DEB + 2));
    wait_n(10);
    check_eq("postrst_state", sw_state[4], 1'b1);
    check_eq("postrst_flag",  press_flag[4], 1'b1);

`ifdef TILETEST_SW_PRESS_COUNT_EN
    for (int p = 0; p < 300; p++) begin
      drive_sw(0, 1'b1, 1'b1);
      wait_n(7);
      drive_sw(0, 1'b0, 1'b1);
      wait_n(7);
    end
    check_eq("count_sat", press_count[7:0], 8'd255);
    check_eq("count_sw4", press_count[39:32], 8'd1);
    count_clr = 1'b1;
    wait_n(1);
    count_clr = 1'b0;
    check_eq("count_clr", press_count, 0);
    drive_sw(0, 1'b1, 1'b1);
    wait_n(7);
    check_eq("count_one", press_count[7:0], 8'd1);
    drive_sw(0, 1'b0, 1'b1);
    wait_n(7);
    drive_sw(0, 1'b1, 1'b1);
    wait_n(6);
    count_clr = 1'b1;
    wait_n(1);
    count_clr = 1'b0;
    check_eq("count_clr_race", press_count[7:0], 8'd0);
`else
    check_eq("count_tied", press_count, 0);
`endif

    wait_n(10);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
